// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM states,
// default operand width and the bit-counter width helper.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;

    // Floor of one bit so WIDTH=2 still gets a usable counter.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/adder.sv
// Shared 1-bit full adder datapath cell; purely combinational.
module adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: sequences one full adder LSB-first over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] ps;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_cout;
    logic             start_acc;
    logic             last_bit;
    logic [WIDTH-1:0] ps_full;

    adder u_adder (
        .A   (a_sr[0]),
        .B   (b_sr[0]),
        .Cin (carry),
        .S   (fa_s),
        .Cout(fa_cout)
    );

    assign start_acc = start && (state != RUN);
    assign last_bit  = (state == RUN) && (cnt == CW'(WIDTH - 1));
    // Newest sum bit enters at the top; after WIDTH shifts bit 0 reaches the bottom.
    assign ps_full   = {fa_s, ps};
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            ps    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (start_acc) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            ps    <= ps_full[WIDTH-1:1];
            carry <= fa_cout;
            cnt   <= cnt + CW'(1);
            if (last_bit) begin
                sum  <= ps_full;
                cout <= fa_cout;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic c_msb;

    // Carry into the MSB is the carry out of bit WIDTH-2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_msb <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == RUN) begin
            if (cnt == CW'(WIDTH - 2)) c_msb <= fa_cout;
            if (last_bit)              ovf   <= c_msb ^ fa_cout;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed plus randomized bench for serial_adder_ctrl against an arithmetic model.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned addition; overflow from operand/result sign rule.
    task automatic model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
        logic [W:0] t;
        t        = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
        exp_sum  = t[W-1:0];
        exp_cout = t[W];
        exp_ovf  = (ia[W-1] == ib[W-1]) && (exp_sum[W-1] != ia[W-1]);
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
        @(negedge clk);
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc = 0;
        busy_cyc = 0;
        while (done !== 1'b1 && cyc < W + 4) begin
            if (busy === 1'b1) busy_cyc++;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check_result(input string tag);
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
    endtask

    task automatic full_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                           input string tag);
        int cyc, bc;
        model(ia, ib, ic);
        issue(ia, ib, ic);
        wait_done(cyc, bc);
        check({tag, "_latency"}, 32'(cyc), 32'(W));
        check({tag, "_busycyc"}, 32'(bc), 32'(W));
        check_result(tag);
        @(posedge clk);
        #1;
        check({tag, "_donefall"}, 32'(done), 32'd0);
        check({tag, "_idlebusy"}, 32'(busy), 32'd0);
    endtask

    task automatic count_dones(input int ncyc, output int nd);
        nd = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) nd++;
        end
    endtask

    initial begin
        int cyc, bc, nd;
        logic [W-1:0] ra, rb;
        logic         rc;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(3, nd);
        check("idle_nodone", 32'(nd), 32'd0);

        full_op(8'h0F, 8'h01, 1'b0, "d0f01");
        check("d0f01_const", 32'(sum), 32'h10);
        full_op(8'hFF, 8'h01, 1'b0, "dff01");
        check("dff01_cout_const", 32'(cout), 32'd1);
        full_op(8'h00, 8'h00, 1'b1, "d0000c");
        check("d0000c_const", 32'(sum), 32'h01);

        // Second start mid-RUN must be ignored.
        model(8'h12, 8'h34, 1'b0);
        issue(8'h12, 8'h34, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; a = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc, bc);
        check("ign_latency", 32'(cyc), 32'(W - 3));
        check_result("ign");
        check("ign_const", 32'(sum), 32'h46);
        count_dones(W + 3, nd);
        check("ign_single_done", 32'(nd), 32'd0);
        check("ign_sum_hold", 32'(sum), 32'h46);

        // Back-to-back: start held through the DONE cycle.
        ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
        model(ra, rb, rc);
        issue(ra, rb, rc);
        wait_done(cyc, bc);
        check("b2b1_latency", 32'(cyc), 32'(W));
        check_result("b2b1");
        start = 1'b1; a = 8'hA0; b = 8'h0A; cin = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_nogap_busy", 32'(busy), 32'd1);
        model(8'hA0, 8'h0A, 1'b0);
        wait_done(cyc, bc);
        check("b2b2_latency", 32'(cyc + 1), 32'(W + 1));
        check_result("b2b2");
        check("b2b2_const", 32'(sum), 32'hAA);

        // Asynchronous reset mid-RUN.
        @(posedge clk);
        #1;
        issue(8'h33, 8'h44, 1'b1);
        repeat (3) @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_sum", 32'(sum), 32'd0);
        check("arst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(W + 3, nd);
        check("arst_nodone", 32'(nd), 32'd0);
        check("arst_idle", 32'(busy), 32'd0);
        full_op(8'h5A, 8'h27, 1'b0, "post_rst");

`ifdef SERIAL_ADD_OVF_EN
        full_op(8'h7F, 8'h01, 1'b0, "ovf7f");
        check("ovf7f_const", 32'(ovf), 32'd1);
        full_op(8'hFF, 8'h01, 1'b0, "ovfff");
        check("ovfff_const", 32'(ovf), 32'd0);
`endif

        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            full_op(ra, rb, rc, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller sequencing the team's 1-bit full adder `adder` over WIDTH clock cycles to add two WIDTH-bit operands. It loads both operands on a start request, feeds one bit pair per cycle into the full adder, and registers the carry between cycles. It returns the WIDTH-bit sum and final carry with a one-cycle `done` pulse. It sits between a requesting sequencer and the shared single-bit adder datapath, trading latency for area.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 2..32.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset; clears all state immediately on assertion.
- `start`  in  1: request a new addition; sampled on the rising edge.
- `a`  in  WIDTH: operand A; captured only when `start` is accepted.
- `b`  in  WIDTH: operand B; captured only when `start` is accepted.
- `cin`  in  1: carry-in to bit 0; captured only when `start` is accepted.
- `busy`  out  1: high while bits are being processed (state RUN).
- `done`  out  1: one-cycle pulse; `sum` and `cout` are valid from this cycle.
- `sum`  out  WIDTH: result register; holds its value until the next completion.
- `cout`  out  1: carry out of bit WIDTH-1; holds its value like `sum`.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- Reset values: `busy`=0, `done`=0, `sum`=0, `cout`=0, and all internal registers are 0.
- IDLE or DONE with `start`=1:
  - load `a` and `b` into shift registers;
  - load `cin` into the carry flip-flop;
  - clear the bit counter;
  - go to RUN.
- IDLE with `start`=0: stay in IDLE.
- DONE with `start`=0: go to IDLE.
- RUN, each cycle:
  - full-adder inputs: A = LSB of A shift register, B = LSB of B shift register, Cin = carry flip-flop;
  - A and B shift registers shift right by one;
  - S shifts into the MSB of the partial-sum register;
  - carry flip-flop takes Cout;
  - counter increments.
- RUN when the counter reaches WIDTH-1 (last bit):
  - `sum` takes the completed partial-sum value;
  - `cout` takes Cout;
  - go to DONE.
- `start` in RUN is ignored. It is not queued, and operands on `a`/`b` are not sampled.
- `done` = (state == DONE). `busy` = (state == RUN).
- Arithmetic is unsigned modulo 2^WIDTH. `cout` is the (WIDTH+1)th bit.

## Timing
- `start` sampled at edge k → `busy`=1 from edge k to edge k+WIDTH.
- `sum`/`cout` update and `done`=1 at edge k+WIDTH; `done` deasserts at edge k+WIDTH+1.
- Latency: WIDTH+1 cycles from the `start` edge to the end of the `done` cycle. Throughput is one addition per WIDTH+1 cycles back-to-back.
- Back-to-back: `start`=1 during the DONE cycle is accepted, and RUN follows with no IDLE gap.
- `rst_n` low mid-RUN aborts the operation. Outputs go to reset values asynchronously, and the FSM stays in IDLE until the first edge after `rst_n` rises.
- `sum`/`cout` never change except at the last RUN edge or on reset.

## Configuration
- `SERIAL_ADD_OVF_EN` defined:
  - adds output `ovf`  out  1, the two's-complement signed overflow;
  - `ovf` = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1;
  - the carry into bit WIDTH-1 is captured on the edge that processes bit WIDTH-2;
  - `ovf` is registered with `sum`, holds like `sum`, and resets to 0.
- `SERIAL_ADD_OVF_EN` undefined: no `ovf` port and no related flops.

## Structure
- Shared package `serial_add_pkg` holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - the default WIDTH constant;
  - a function returning the counter width, $clog2(WIDTH).
- The only sub-module is the existing 1-bit full adder `adder` (ports A, B, Cin, S, Cout), instantiated once and driven purely combinationally.
- All sequencing, shift registers, carry flop and output registers live in `serial_adder_ctrl`.

## Test plan
- WIDTH=8: a=8'h0F, b=8'h01, cin=0, start pulse → `done` at edge k+8, sum=8'h10, cout=0, busy high for exactly 8 cycles.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=8'h00, b=8'h00, cin=1 → sum=8'h01, cout=0.
- Start a=8'h12, b=8'h34; pulse start again at edge k+3 with a=8'hFF → the second start is ignored, sum=8'h46, single `done` pulse.
- Back-to-back: second start (a=8'hA0, b=8'h0A) held high during the `done` cycle → second `done` 9 cycles after the first, sum=8'hAA.
- Assert rst_n=0 at edge k+4 → busy, done, sum, cout = 0 immediately; no `done` after release; the next start completes normally.
- With `SERIAL_ADD_OVF_EN`: 8'h7F+8'h01 → sum=8'h80, cout=0, ovf=1; 8'hFF+8'h01 → ovf=0.
